pipeline_ctrl: RTL and testbench

Global stall/flush sequencer for the five-stage RV32I pipeline. Sits beside the stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register, and drives their `load` and flush controls. It waits on instruction- and data-memory responses, inserts a bubble on load-use hazards, and squashes wrong-path instructions on a taken branch or jump. It also owns the instruction-fetch request strobe.

---
 rtl/rv32i_types.sv | 22 ++
 rtl/hazard_detect.sv | 18 +
 rtl/pipeline_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types: sequencer states and stage control bundle
package rv32i_types;

  typedef enum logic {
    START = 1'b0,
    RUN   = 1'b1
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic pc_sel;
    logic flush_if_id;
    logic flush_id_ex;
  } pipe_ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between EX destination and ID sources
module hazard_detect
  import rv32i_types::*;
(
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       hz
);

  // x0 is never a real dependency, so a load into x0 cannot cause a stall
  assign hz = ex_is_load && (ex_rd != REG_X0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - global stall/flush sequencer; PIPE_CTRL_PERF_EN builds the perf counters
module pipeline_ctrl
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_resp,
  input  logic        dmem_resp,
  input  logic        mem_req,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  output logic        imem_read,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        pc_sel,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubble_count,
  output logic [31:0] flush_count
);

  pipe_ctrl_state_t state_q, state_d;
  logic             imem_done_q, imem_done_d;
  logic             dmem_done_q, dmem_done_d;
  logic             hz;
  logic             adv;
  logic             active;
  pipe_ctrl_t       ctrl;

  hazard_detect u_hazard_detect (
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .hz         (hz)
  );

  // Outputs are forced quiet while reset is held, even before the state register clears
  assign active = rst && (state_q == RUN);
  assign adv    = active && (imem_resp || imem_done_q) && (!mem_req || dmem_resp || dmem_done_q);

  always_comb begin
    state_d     = RUN;
    imem_done_d = imem_done_q;
    dmem_done_d = dmem_done_q;
    ctrl        = '0;
    imem_read   = 1'b0;
    if (active) begin
      imem_read = !imem_done_q;
      if (!adv) begin
        imem_done_d = imem_done_q || imem_resp;
        dmem_done_d = dmem_done_q || dmem_resp;
      end else if (ex_br_taken) begin
        ctrl        = '{default: 1'b1};
        imem_done_d = 1'b0;
        dmem_done_d = 1'b0;
      end else if (hz) begin
        // PC holds, so the instruction already fetched stays valid for the retry
        ctrl.load_id_ex  = 1'b1;
        ctrl.flush_id_ex = 1'b1;
        ctrl.load_ex_mem = 1'b1;
        ctrl.load_mem_wb = 1'b1;
        imem_done_d      = 1'b1;
        dmem_done_d      = 1'b0;
      end else begin
        ctrl.load_pc     = 1'b1;
        ctrl.load_if_id  = 1'b1;
        ctrl.load_id_ex  = 1'b1;
        ctrl.load_ex_mem = 1'b1;
        ctrl.load_mem_wb = 1'b1;
        imem_done_d      = 1'b0;
        dmem_done_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= START;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_done_q <= imem_done_d;
      dmem_done_q <= dmem_done_d;
    end
  end

  assign load_pc     = ctrl.load_pc;
  assign load_if_id  = ctrl.load_if_id;
  assign load_id_ex  = ctrl.load_id_ex;
  assign load_ex_mem = ctrl.load_ex_mem;
  assign load_mem_wb = ctrl.load_mem_wb;
  assign pc_sel      = ctrl.pc_sel;
  assign flush_if_id = ctrl.flush_if_id;
  assign flush_id_ex = ctrl.flush_id_ex;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, bubble_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else if (active) begin
      if (!adv) begin
        stall_q <= stall_q + 32'd1;
      end else if (ex_br_taken) begin
        flush_q <= flush_q + 32'd1;
      end else if (hz) begin
        bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign stall_cycles = rst ? stall_q  : '0;
  assign bubble_count = rst ? bubble_q : '0;
  assign flush_count  = rst ? flush_q  : '0;
`else
  assign stall_cycles = '0;
  assign bubble_count = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [8:0] IDLE_0 = 9'b0_00000_000;
  localparam logic [8:0] STALL  = 9'b1_00000_000;
  localparam logic [8:0] ADV_R  = 9'b1_11111_000;
  localparam logic [8:0] ADV_N  = 9'b0_11111_000;
  localparam logic [8:0] BUBBLE = 9'b1_00111_001;
  localparam logic [8:0] BRANCH = 9'b1_11111_111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_resp, dmem_resp, mem_req;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken;
  logic        imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        pc_sel, flush_if_id, flush_id_ex;
  logic [31:0] stall_cycles, bubble_count, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp), .mem_req(mem_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .imem_read(imem_read), .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb), .pc_sel(pc_sel),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count)
  );

  wire [8:0] obs = {imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                    pc_sel, flush_if_id, flush_id_ex};

  // Reference model: "started" bit, two "already have it" bits, and event tallies
  bit          m_run, m_have_instr, m_have_data;
  logic [31:0] m_stall, m_bubble, m_flush;

  function automatic bit m_go();
    return (imem_resp || m_have_instr) && (!mem_req || dmem_resp || m_have_data);
  endfunction

  function automatic bit m_lu();
    return ex_is_load && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [8:0] exp_obs();
    logic [8:0] e;
    e = '0;
    if (rst && m_run) begin
      e[8] = !m_have_instr;
      if (m_go()) begin
        if (ex_br_taken)  e[7:0] = 8'hFF;
        else if (m_lu())  e[7:0] = 8'b00111_001;
        else              e[7:0] = 8'b11111_000;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_run <= 0; m_have_instr <= 0; m_have_data <= 0;
      m_stall <= 0; m_bubble <= 0; m_flush <= 0;
    end else if (!m_run) begin
      m_run <= 1;
    end else if (!m_go()) begin
      m_stall      <= m_stall + 1;
      m_have_instr <= m_have_instr | imem_resp;
      m_have_data  <= m_have_data | dmem_resp;
    end else if (ex_br_taken) begin
      m_flush <= m_flush + 1; m_have_instr <= 0; m_have_data <= 0;
    end else if (m_lu()) begin
      m_bubble <= m_bubble + 1; m_have_instr <= 1; m_have_data <= 0;
    end else begin
      m_have_instr <= 0; m_have_data <= 0;
    end
  end

  task automatic set_idle();
    imem_resp = 0; dmem_resp = 0; mem_req = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_is_load = 0; ex_br_taken = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Leaves the bench in the first RUN cycle with fresh counters
  task automatic do_reset();
    set_idle(); rst = 0;
    tick(); tick();
    rst = 1;
    tick();
  endtask

  task automatic test_reset();
    set_idle(); rst = 0; imem_resp = 1; mem_req = 1; dmem_resp = 1;
    tick(); tick();
    @(negedge clk);
    checks++; if (obs !== IDLE_0) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs, IDLE_0); end
    checks++; if (stall_cycles !== 0 || bubble_count !== 0 || flush_count !== 0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", stall_cycles, bubble_count, flush_count); end
    tick();
    set_idle(); rst = 1; imem_resp = 1;
    @(negedge clk);
    checks++; if (obs !== IDLE_0) begin errors++; $display("FAIL start_cycle: got %b want %b", obs, IDLE_0); end
    tick();
  endtask

  task automatic test_no_mem();
    do_reset(); imem_resp = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (obs !== ADV_R) begin errors++; $display("FAIL no_mem_adv[%0d]: got %b want %b", i, obs, ADV_R); end
      tick();
    end
    @(negedge clk);
    checks++; if (stall_cycles !== 0) begin errors++; $display("FAIL no_mem_stall: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_imem_delay();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (obs !== STALL) begin errors++; $display("FAIL imem_wait[%0d]: got %b want %b", i, obs, STALL); end
      tick();
    end
    imem_resp = 1;
    @(negedge clk);
    checks++; if (obs !== ADV_R) begin errors++; $display("FAIL imem_adv: got %b want %b", obs, ADV_R); end
    tick();
    imem_resp = 0;
    @(negedge clk);
    checks++; if (obs !== STALL) begin errors++; $display("FAIL imem_refetch: got %b want %b", obs, STALL); end
    checks++; if (stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin
      errors++; $display("FAIL imem_stall_count: got %0d want %0d", stall_cycles, PERF ? 3 : 0); end
  endtask

  task automatic test_dmem_wait();
    logic [8:0] want [5] = '{STALL, STALL, IDLE_0, IDLE_0, ADV_N};
    do_reset(); mem_req = 1;
    for (int i = 0; i < 5; i++) begin
      imem_resp = (i == 1);
      dmem_resp = (i == 4);
      @(negedge clk);
      checks++; if (obs !== want[i]) begin errors++; $display("FAIL dmem_cycle[%0d]: got %b want %b", i, obs, want[i]); end
      tick();
    end
    set_idle();
    @(negedge clk);
    checks++; if (obs !== STALL) begin errors++; $display("FAIL dmem_after: got %b want %b", obs, STALL); end
    checks++; if (stall_cycles !== (PERF ? 32'd4 : 32'd0)) begin
      errors++; $display("FAIL dmem_stall_count: got %0d want %0d", stall_cycles, PERF ? 4 : 0); end
  endtask

  task automatic test_load_use();
    do_reset();
    imem_resp = 1; ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 7; id_use_rs1 = 1;
    @(negedge clk);
    checks++; if (obs !== BUBBLE) begin errors++; $display("FAIL load_use_bubble: got %b want %b", obs, BUBBLE); end
    tick();
    set_idle();
    @(negedge clk);
    checks++; if (obs !== ADV_N) begin errors++; $display("FAIL load_use_resume: got %b want %b", obs, ADV_N); end
    checks++; if (bubble_count !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL bubble_count: got %0d want %0d", bubble_count, PERF ? 1 : 0); end
    tick();
    imem_resp = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    @(negedge clk);
    checks++; if (obs !== ADV_R) begin errors++; $display("FAIL load_x0_no_hazard: got %b want %b", obs, ADV_R); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    ex_br_taken = 1; imem_resp = 0;
    @(negedge clk);
    checks++; if (obs !== STALL) begin errors++; $display("FAIL branch_stalled: got %b want %b", obs, STALL); end
    imem_resp = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    @(negedge clk);
    checks++; if (obs !== BRANCH) begin errors++; $display("FAIL branch_flush: got %b want %b", obs, BRANCH); end
    tick();
    set_idle(); imem_resp = 1;
    @(negedge clk);
    checks++; if (obs !== ADV_R) begin errors++; $display("FAIL branch_after: got %b want %b", obs, ADV_R); end
    checks++; if (flush_count !== (PERF ? 32'd1 : 32'd0) || bubble_count !== 0) begin
      errors++; $display("FAIL branch_counts: got flush %0d bubble %0d want %0d 0", flush_count, bubble_count, PERF ? 1 : 0); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset(); mem_req = 1; imem_resp = 1;
    tick();
    imem_resp = 0;
    @(negedge clk);
    checks++; if (obs !== IDLE_0) begin errors++; $display("FAIL mid_stall_hold: got %b want %b", obs, IDLE_0); end
    rst = 0; imem_resp = 1; dmem_resp = 1;
    @(negedge clk);
    checks++; if (obs !== IDLE_0 || stall_cycles !== 0) begin
      errors++; $display("FAIL mid_stall_reset: got %b cnt %0d want %b cnt 0", obs, stall_cycles, IDLE_0); end
    tick();
    set_idle(); rst = 1;
    tick();
    @(negedge clk);
    checks++; if (obs !== STALL) begin errors++; $display("FAIL after_reset_fetch: got %b want %b", obs, STALL); end
    tick();
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 59) != 0);
      imem_resp   = ($urandom_range(0, 2) == 0);
      dmem_resp   = ($urandom_range(0, 2) == 0);
      mem_req     = $urandom_range(0, 1) == 1;
      ex_is_load  = $urandom_range(0, 1) == 1;
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = $urandom_range(0, 1) == 1;
      id_use_rs2  = $urandom_range(0, 1) == 1;
      ex_br_taken = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      e = exp_obs();
      checks++; if (obs !== e) begin errors++; $display("FAIL random_ctrl[%0d]: got %b want %b", i, obs, e); end
      checks++;
      if (stall_cycles !== (PERF && rst ? m_stall : 32'd0) || bubble_count !== (PERF && rst ? m_bubble : 32'd0) ||
          flush_count !== (PERF && rst ? m_flush : 32'd0)) begin
        errors++; $display("FAIL random_counters[%0d]: got %0d/%0d/%0d model %0d/%0d/%0d", i,
                           stall_cycles, bubble_count, flush_count, m_stall, m_bubble, m_flush);
      end
      tick();
    end
    rst = 1;
  endtask

  initial begin
    set_idle();
    test_reset();
    test_no_mem();
    test_imem_delay();
    test_dmem_wait();
    test_load_use();
    test_branch();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
